// File: rtl/alarm_bank.sv
// Multi-channel alarm unit: per-channel stored times and enables, a shared
// five-button editor, snooze with wrap-around target, and a ring timeout.
module alarm_bank #(
  parameter  int NUM_ALARMS = 4,
  parameter  int TIME_W     = 11,
  parameter  int MODE_SEL   = 3,
  parameter  int LOCK_CYC   = 2000,
  parameter  int SNOOZE_MIN = 5,
  parameter  int RING_SECS  = 60,
  localparam int IW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic              newclk,
  input  logic              reset,
  input  logic [5:0]        mode,
  input  logic              up,
  input  logic              down,
  input  logic              left,
  input  logic              right,
  input  logic              middle,
  input  logic              snooze,
  input  logic              switch,
  input  logic [TIME_W-1:0] hour,
  input  logic [TIME_W-1:0] minute,
  input  logic [TIME_W-1:0] second,
  output logic [2:0]        alarm_mode,
  output logic [IW-1:0]     sel,
  output logic [TIME_W-1:0] temp_hour,
  output logic [TIME_W-1:0] temp_minute,
  output logic [TIME_W-1:0] temp_second,
  output logic [NUM_ALARMS-1:0] enable,
  output logic              ring_req,
  output logic [IW-1:0]     ring_idx
);

  localparam int LCW = $clog2(LOCK_CYC + 1);
  localparam int RCW = $clog2(RING_SECS + 2);

  typedef enum logic [2:0] {
    AM_IDLE = 3'd0, AM_SEC = 3'd1, AM_MIN = 3'd2,
    AM_HOUR = 3'd3, AM_CHAN = 3'd4, AM_EN = 3'd5
  } am_t;

  am_t state_q, state_d;
  logic                                 lock;
  logic [LCW-1:0]                       lcnt;
  logic [NUM_ALARMS-1:0][TIME_W-1:0]    ch_h, ch_m, ch_s;
  logic [NUM_ALARMS-1:0]                valid;
  logic [TIME_W-1:0]                    prev_second;
  logic [RCW-1:0]                       rcnt;
  logic                                 snz_pend;
  logic [IW-1:0]                        snz_ch;
  logic [TIME_W-1:0]                    snz_h, snz_m, snz_s;

  function automatic logic [TIME_W-1:0] step_val(input logic [TIME_W-1:0] v,
                                                 input logic [TIME_W-1:0] max,
                                                 input logic inc);
    if (inc) step_val = (v >= max) ? '0 : v + 1'b1;
    else     step_val = (v == '0 || v > max) ? max : v - 1'b1;
  endfunction

  logic edit_on;
  assign edit_on    = (mode == 6'(MODE_SEL));
  assign alarm_mode = edit_on ? state_q : AM_IDLE;

  // One button per press; priority middle > left > right > up > down > snooze.
  logic any_btn, acc;
  logic acc_mid, acc_left, acc_right, acc_up, acc_down, acc_snz;
  assign any_btn   = up | down | left | right | middle | snooze;
  assign acc       = any_btn & ~lock;
  assign acc_mid   = acc & middle;
  assign acc_left  = acc & ~middle & left;
  assign acc_right = acc & ~middle & ~left & right;
  assign acc_up    = acc & ~middle & ~left & ~right & up;
  assign acc_down  = acc & ~middle & ~left & ~right & ~up & down;
  assign acc_snz   = acc & ~middle & ~left & ~right & ~up & ~down & snooze;

  always_ff @(posedge newclk) begin
    if (reset) begin
      lock <= 1'b0;
      lcnt <= '0;
    end else if (acc) begin
      lock <= 1'b1;
      lcnt <= '0;
    end else if (any_btn) begin
      lcnt <= '0;
    end else if (lock) begin
      if (lcnt == LCW'(LOCK_CYC - 1)) begin
        lock <= 1'b0;
        lcnt <= '0;
      end else begin
        lcnt <= lcnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (!edit_on)
      state_d = AM_IDLE;
    else if (acc_mid)
      state_d = (state_q == AM_IDLE) ? AM_SEC : AM_IDLE;
    else if (acc_left && state_q != AM_IDLE)
      state_d = (state_q == AM_EN) ? AM_SEC : am_t'(3'(state_q) + 3'd1);
    else if (acc_right && state_q != AM_IDLE)
      state_d = (state_q == AM_SEC) ? AM_EN : am_t'(3'(state_q) - 3'd1);
  end

  always_ff @(posedge newclk) begin
    if (reset) state_q <= AM_IDLE;
    else       state_q <= state_d;
  end

  logic e_step;
  assign e_step = edit_on & (acc_up | acc_down);

  always_ff @(posedge newclk) begin
    if (reset) begin
      sel    <= '0;
      enable <= '0;
      valid  <= '0;
      ch_h   <= '0;
      ch_m   <= '0;
      ch_s   <= '0;
    end else begin
      // First entry into edit on an unset channel seeds it with the current time.
      if (edit_on && acc_mid && state_q == AM_IDLE && !valid[sel]) begin
        ch_h[sel]  <= hour;
        ch_m[sel]  <= minute;
        ch_s[sel]  <= second;
        valid[sel] <= 1'b1;
      end
      if (e_step) begin
        case (state_q)
          AM_SEC:  ch_s[sel] <= step_val(ch_s[sel], TIME_W'(59), acc_up);
          AM_MIN:  ch_m[sel] <= step_val(ch_m[sel], TIME_W'(59), acc_up);
          AM_HOUR: ch_h[sel] <= step_val(ch_h[sel], TIME_W'(23), acc_up);
          AM_CHAN:
            if (acc_up) sel <= (sel == IW'(NUM_ALARMS - 1)) ? '0 : sel + 1'b1;
            else        sel <= (sel == '0) ? IW'(NUM_ALARMS - 1) : sel - 1'b1;
          AM_EN:   enable[sel] <= acc_up;
          default: ;
        endcase
      end
    end
  end

  assign temp_hour   = ch_h[sel];
  assign temp_minute = ch_m[sel];
  assign temp_second = ch_s[sel];

  logic                  tick;
  logic [NUM_ALARMS-1:0] mt;
  logic                  hit, snz_hit, trig;
  logic [IW-1:0]         hit_idx;
  logic [TIME_W-1:0]     sum_m, tgt_h, tgt_m;

  assign tick = (second != prev_second);

  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < NUM_ALARMS; i++)
      mt[i] = enable[i] && ch_h[i] == hour && ch_m[i] == minute && ch_s[i] == second;
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      if (mt[i]) hit_idx = IW'(i);
  end

  assign hit     = |mt;
  assign snz_hit = snz_pend && snz_h == hour && snz_m == minute && snz_s == second;
  assign trig    = tick && alarm_mode == 3'd0 && !ring_req && (hit || snz_hit);

  always_comb begin
    sum_m = minute + TIME_W'(SNOOZE_MIN);
    tgt_m = sum_m;
    tgt_h = hour;
    if (sum_m >= TIME_W'(60)) begin
      tgt_m = sum_m - TIME_W'(60);
      tgt_h = (hour >= TIME_W'(23)) ? '0 : hour + 1'b1;
    end
  end

  always_ff @(posedge newclk) begin
    prev_second <= second;
    if (reset) begin
      ring_req <= 1'b0;
      ring_idx <= '0;
      rcnt     <= '0;
      snz_pend <= 1'b0;
      snz_ch   <= '0;
      snz_h    <= '0;
      snz_m    <= '0;
      snz_s    <= '0;
    end else if (switch) begin
      ring_req <= 1'b0;
      snz_pend <= 1'b0;
    end else if (trig) begin
      ring_req <= 1'b1;
      rcnt     <= '0;
      if (hit) begin
        ring_idx <= hit_idx;
      end else begin
        ring_idx <= snz_ch;
        snz_pend <= 1'b0;
      end
    end else if (ring_req) begin
      if (acc_snz) begin
        ring_req <= 1'b0;
        snz_pend <= 1'b1;
        snz_ch   <= ring_idx;
        snz_h    <= tgt_h;
        snz_m    <= tgt_m;
        snz_s    <= second;
      end else if (tick && RING_SECS != 0) begin
        rcnt <= rcnt + 1'b1;
        if (rcnt + 1'b1 == RCW'(RING_SECS)) ring_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: a table of editor button presses plus
// hand-written sequences for wrap, lockout, trigger, ring timeout, snooze and dismiss.
module tb_alarm_bank;
  localparam int NA = 4, TW = 11;
  localparam int B_MID = 0, B_LEFT = 1, B_RIGHT = 2, B_UP = 3, B_DOWN = 4, B_SNZ = 5;

  logic newclk = 1'b0, reset = 1'b0;
  logic [5:0] mode = 6'd3;
  logic up = 0, down = 0, left = 0, right = 0, middle = 0, snooze = 0, switch = 0;
  logic [TW-1:0] hour = 11'd10, minute = 11'd20, second = 11'd30;
  logic [2:0] alarm_mode;
  logic [1:0] sel, ring_idx;
  logic [TW-1:0] temp_hour, temp_minute, temp_second;
  logic [NA-1:0] enable;
  logic ring_req;

  int n_tests = 0, n_fail = 0, cur_sel = 0;

  alarm_bank #(.NUM_ALARMS(NA), .TIME_W(TW), .MODE_SEL(3), .LOCK_CYC(4),
               .SNOOZE_MIN(5), .RING_SECS(3)) dut (
    .newclk(newclk), .reset(reset), .mode(mode), .up(up), .down(down), .left(left),
    .right(right), .middle(middle), .snooze(snooze), .switch(switch), .hour(hour),
    .minute(minute), .second(second), .alarm_mode(alarm_mode), .sel(sel),
    .temp_hour(temp_hour), .temp_minute(temp_minute), .temp_second(temp_second),
    .enable(enable), .ring_req(ring_req), .ring_idx(ring_idx));

  always #5 newclk = ~newclk;

  typedef struct {
    int btn;
    int am;
    int h, m, s;
    int sl;
    int en;
  } vec_t;
  vec_t tbl[22];

  task automatic step();
    @(posedge newclk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_MID:   middle = v;
      B_LEFT:  left   = v;
      B_RIGHT: right  = v;
      B_UP:    up     = v;
      B_DOWN:  down   = v;
      default: snooze = v;
    endcase
  endtask

  // Press for one cycle, then hold all released long enough to clear the lockout.
  task automatic press(input int b);
    set_btn(b, 1'b1);
    step();
    set_btn(b, 1'b0);
    repeat (5) step();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hour = TW'(h); minute = TW'(m); second = TW'(s);
    step();
  endtask

  function automatic int tmp();
    return int'(temp_hour) * 10000 + int'(temp_minute) * 100 + int'(temp_second);
  endfunction

  // From idle: select channel k, seed it if unset, arm it, return to idle.
  task automatic arm(input int k, input logic on);
    press(B_MID);
    repeat (3) press(B_LEFT);
    while (cur_sel != k) begin
      press(B_UP);
      cur_sel = (cur_sel + 1) % NA;
    end
    press(B_MID);
    press(B_MID);
    press(B_RIGHT);
    press(on ? B_UP : B_DOWN);
    press(B_MID);
  endtask

  initial begin
    tbl[0]  = '{B_MID,   1, 10, 20, 30, 0, 0};
    tbl[1]  = '{B_UP,    1, 10, 20, 31, 0, 0};
    tbl[2]  = '{B_DOWN,  1, 10, 20, 30, 0, 0};
    tbl[3]  = '{B_LEFT,  2, 10, 20, 30, 0, 0};
    tbl[4]  = '{B_DOWN,  2, 10, 19, 30, 0, 0};
    tbl[5]  = '{B_LEFT,  3, 10, 19, 30, 0, 0};
    tbl[6]  = '{B_UP,    3, 11, 19, 30, 0, 0};
    tbl[7]  = '{B_LEFT,  4, 11, 19, 30, 0, 0};
    tbl[8]  = '{B_UP,    4,  0,  0,  0, 1, 0};
    tbl[9]  = '{B_LEFT,  5,  0,  0,  0, 1, 0};
    tbl[10] = '{B_UP,    5,  0,  0,  0, 1, 2};
    tbl[11] = '{B_DOWN,  5,  0,  0,  0, 1, 0};
    tbl[12] = '{B_RIGHT, 4,  0,  0,  0, 1, 0};
    tbl[13] = '{B_DOWN,  4, 11, 19, 30, 0, 0};
    tbl[14] = '{B_RIGHT, 3, 11, 19, 30, 0, 0};
    tbl[15] = '{B_RIGHT, 2, 11, 19, 30, 0, 0};
    tbl[16] = '{B_RIGHT, 1, 11, 19, 30, 0, 0};
    tbl[17] = '{B_RIGHT, 5, 11, 19, 30, 0, 0};
    tbl[18] = '{B_LEFT,  1, 11, 19, 30, 0, 0};
    tbl[19] = '{B_MID,   0, 11, 19, 30, 0, 0};
    tbl[20] = '{B_MID,   1, 11, 19, 30, 0, 0};
    tbl[21] = '{B_MID,   0, 11, 19, 30, 0, 0};

    reset = 1'b1;
    repeat (2) step();
    chk("rst_am", alarm_mode, 0);
    chk("rst_sel", sel, 0);
    chk("rst_en", enable, 0);
    chk("rst_ring", ring_req, 0);
    chk("rst_idx", ring_idx, 0);
    chk("rst_temp", tmp(), 0);
    reset = 1'b0;
    step();

    foreach (tbl[i]) begin
      press(tbl[i].btn);
      chk($sformatf("tbl%0d_am", i), alarm_mode, tbl[i].am);
      chk($sformatf("tbl%0d_temp", i), tmp(), tbl[i].h * 10000 + tbl[i].m * 100 + tbl[i].s);
      chk($sformatf("tbl%0d_sel", i), sel, tbl[i].sl);
      chk($sformatf("tbl%0d_en", i), enable, tbl[i].en);
    end

    // Seed ch2 at 00:00:59, then second and hour wrap.
    press(B_MID);
    repeat (3) press(B_LEFT);
    press(B_UP); press(B_UP); cur_sel = 2;
    press(B_MID);
    set_time(0, 0, 59);
    press(B_MID);
    chk("seed_ch2", tmp(), 59);
    press(B_UP);
    chk("sec_wrap", temp_second, 0);
    press(B_LEFT); press(B_LEFT);
    chk("am_hour", alarm_mode, 3);
    press(B_DOWN);
    chk("hour_wrap", temp_hour, 23);
    press(B_UP);
    chk("hour_wrap_up", temp_hour, 0);

    // Second press during the lockout window is dropped; a held button counts once.
    up = 1; step(); up = 0; step(); up = 1; step(); up = 0;
    repeat (5) step();
    chk("lock_ignore", temp_hour, 1);
    up = 1; repeat (10) step(); up = 0;
    repeat (5) step();
    chk("lock_hold", temp_hour, 2);
    press(B_MID);

    // ch1 and ch3 both at 07:00:00: lower index wins.
    set_time(7, 0, 0);
    arm(1, 1'b1);
    arm(3, 1'b1);
    chk("armed", enable, 4'b1010);
    set_time(6, 59, 59);
    chk("pre_trig", ring_req, 0);
    set_time(7, 0, 0);
    chk("trig", ring_req, 1);
    chk("trig_idx", ring_idx, 1);
    set_time(7, 0, 1);
    set_time(7, 0, 2);
    chk("ring_hold", ring_req, 1);
    set_time(7, 0, 3);
    chk("ring_timeout", ring_req, 0);

    // Disarm ch1 so ch3 rings, then snooze across midnight.
    arm(1, 1'b0);
    chk("disarm", enable, 4'b1000);
    set_time(6, 59, 59);
    set_time(7, 0, 0);
    chk("trig3_idx", ring_idx, 3);
    set_time(23, 58, 10);
    chk("ring_pre_snz", ring_req, 1);
    press(B_SNZ);
    chk("snoozed", ring_req, 0);
    set_time(0, 3, 9);
    chk("snz_early", ring_req, 0);
    set_time(0, 3, 10);
    chk("snz_ring", ring_req, 1);
    chk("snz_idx", ring_idx, 3);

    // Dismiss, dismiss on trigger cycle, and dismiss clearing a pending snooze.
    switch = 1; step(); switch = 0; step();
    chk("dismiss", ring_req, 0);
    set_time(6, 59, 59);
    switch = 1;
    set_time(7, 0, 0);
    chk("sw_trig", ring_req, 0);
    switch = 0; step();
    chk("no_retrig", ring_req, 0);
    set_time(6, 59, 59);
    set_time(7, 0, 0);
    chk("retrig", ring_req, 1);
    press(B_SNZ);
    switch = 1; step(); switch = 0; step();
    set_time(7, 4, 59);
    set_time(7, 5, 0);
    chk("pend_cleared", ring_req, 0);

    // Leaving edit mode forces idle and does not resume.
    press(B_MID); press(B_LEFT);
    chk("am_min", alarm_mode, 2);
    mode = 6'd0; step();
    chk("mode_exit", alarm_mode, 0);
    mode = 6'd3; step();
    chk("mode_back", alarm_mode, 0);

    // Reset in the middle of a ring.
    set_time(6, 59, 59);
    set_time(7, 0, 0);
    chk("ring_pre_rst", ring_req, 1);
    reset = 1; step(); reset = 0;
    chk("rst_ring2", ring_req, 0);
    chk("rst_en2", enable, 0);
    chk("rst_sel2", sel, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
